myled8_pattern_gen: RTL

LED pattern engine that sits directly downstream of the myled8 AXI4-Lite slave register file and consumes its four 32-bit registers (control, period, pattern, duty). It turns the static register contents into a time-varying drive on the 8 board LEDs: static, blink, rotate and bounce modes, with optional PWM dimming. It also returns a status word for read-back through the register file.

---
 rtl/myled8_pattern_gen.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/myled8_pattern_gen.sv
// ----------------------------------------------------------------------------
// myled8_pattern_gen
//   LED pattern engine fed by the myled8 AXI4-Lite register file. Turns the
//   static control/period/pattern/duty words into a time-varying LED drive
//   (STATIC, BLINK, ROTATE_L, BOUNCE) and returns a status word.
//
// Ports
//   ACLK        clock (AXI4-Lite slave domain)
//   ARESET      synchronous active-high reset
//   ctrl_reg    bit0 enable, bits[2:1] mode
//   period_reg  one step every period_reg+1 cycles
//   pattern_reg bits[LED_WIDTH-1:0] seed pattern
//   duty_reg    bits[8:0] PWM duty (only with MYLED8_PWM_EN)
//   cfg_wr      pulse on any register write, forces a reload while running
//   led         registered LED drive
//   tick        single-cycle pulse per step
//   status      {step_cnt[15:0], 13'b0, dir, state[1:0]}, registered
//
// Build option
//   MYLED8_PWM_EN  adds a free-running 8-bit PWM counter that gates led.
// ----------------------------------------------------------------------------
module myled8_pattern_gen #(
    parameter int LED_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [DATA_WIDTH-1:0] ctrl_reg,
    input  logic [DATA_WIDTH-1:0] period_reg,
    input  logic [DATA_WIDTH-1:0] pattern_reg,
    input  logic [DATA_WIDTH-1:0] duty_reg,
    input  logic                  cfg_wr,
    output logic [LED_WIDTH-1:0]  led,
    output logic                  tick,
    output logic [DATA_WIDTH-1:0] status
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_e;

    localparam logic [1:0] M_STATIC = 2'd0;
    localparam logic [1:0] M_BLINK  = 2'd1;
    localparam logic [1:0] M_ROTL   = 2'd2;
    localparam logic [1:0] M_BOUNCE = 2'd3;

    state_e                  state_q, state_d;
    logic [LED_WIDTH-1:0]    sreg_q, sreg_d;
    logic                    phase_q, phase_d;
    logic                    dir_q, dir_d;      // 0 = left, 1 = right
    logic [DATA_WIDTH-1:0]   presc_q, presc_d;
    logic [15:0]             step_q, step_d;
    logic                    tick_q, tick_d;
    logic [LED_WIDTH-1:0]    led_q, led_d;
    logic [DATA_WIDTH-1:0]   status_q, status_d;
    logic [LED_WIDTH-1:0]    led_base;
    logic                    pwm_on;

    logic       en;
    logic [1:0] mode;
    assign en   = ctrl_reg[0];
    assign mode = ctrl_reg[2:1];

`ifdef MYLED8_PWM_EN
    logic [7:0] pwm_q;
    assign pwm_on = ({1'b0, pwm_q} < duty_reg[8:0]);

    always_ff @(posedge ACLK) begin
        if (ARESET) pwm_q <= 8'd0;
        else        pwm_q <= pwm_q + 8'd1;
    end

    logic unused_bits;
    assign unused_bits = ^{ctrl_reg[DATA_WIDTH-1:3], pattern_reg[DATA_WIDTH-1:LED_WIDTH],
                           duty_reg[DATA_WIDTH-1:9]};
`else
    assign pwm_on = 1'b1;

    logic unused_bits;
    assign unused_bits = ^{ctrl_reg[DATA_WIDTH-1:3], pattern_reg[DATA_WIDTH-1:LED_WIDTH],
                           duty_reg};
`endif

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        phase_d = phase_q;
        dir_d   = dir_q;
        presc_d = presc_q;
        step_d  = step_q;
        tick_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                if (en) state_d = S_LOAD;
            end
            S_LOAD: begin
                sreg_d  = pattern_reg[LED_WIDTH-1:0];
                presc_d = '0;
                phase_d = 1'b1;
                dir_d   = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // Priority: disable, then reload, then step.
                if (!en) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                end else if (cfg_wr) begin
                    state_d = S_LOAD;
                    presc_d = '0;
                end else if (presc_q >= period_reg) begin
                    // >= so a period lowered below the running count ticks
                    // immediately instead of running on to wrap.
                    tick_d  = 1'b1;
                    presc_d = '0;
                    step_d  = step_q + 16'd1;
                    case (mode)
                        M_BLINK: phase_d = ~phase_q;
                        M_ROTL:  sreg_d  = {sreg_q[LED_WIDTH-2:0], sreg_q[LED_WIDTH-1]};
                        M_BOUNCE: begin
                            if (!dir_q) begin
                                if (sreg_q[LED_WIDTH-1]) begin
                                    dir_d  = 1'b1;
                                    sreg_d = sreg_q >> 1;
                                end else begin
                                    sreg_d = sreg_q << 1;
                                end
                            end else begin
                                if (sreg_q[0]) begin
                                    dir_d  = 1'b0;
                                    sreg_d = sreg_q << 1;
                                end else begin
                                    sreg_d = sreg_q >> 1;
                                end
                            end
                        end
                        default: ;  // STATIC
                    endcase
                end else begin
                    presc_d = presc_q + DATA_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // LEDs are driven from the next-state view so a step and its LED
        // change land on the same edge; outside RUN the LEDs are dark.
        if (state_d == S_RUN && !(mode == M_BLINK && !phase_d)) led_base = sreg_d;
        else                                                    led_base = '0;
        led_d    = led_base & {LED_WIDTH{pwm_on}};
        status_d = {step_q, 13'b0, dir_q, state_q};
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= S_IDLE;
            sreg_q   <= '0;
            phase_q  <= 1'b0;
            dir_q    <= 1'b0;
            presc_q  <= '0;
            step_q   <= '0;
            tick_q   <= 1'b0;
            led_q    <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            phase_q  <= phase_d;
            dir_q    <= dir_d;
            presc_q  <= presc_d;
            step_q   <= step_d;
            tick_q   <= tick_d;
            led_q    <= led_d;
            status_q <= status_d;
        end
    end

    assign led    = led_q;
    assign tick   = tick_q;
    assign status = status_q;

endmodule
